// File: rtl/coeff_token_ctrl_if.sv
// Bundled handshake, LUT-bank and result signals of the coeff_token decoder.
// slave = decoder side, master = the environment driving windows and the LUT bank.
interface coeff_token_ctrl_if;
    logic        Flush;
    logic        InValid;
    logic        InReady;
    logic [15:0] InBits;
    logic [1:0]  NcClass;
    logic [1:0]  LutClass;
    logic [3:0]  LutPrefix;
    logic [3:0]  LutBits;
    logic        LutReq;
    logic [4:0]  LutTotalCoeff;
    logic [1:0]  LutTrailingOnes;
    logic [4:0]  LutLen;
    logic        LutHit;
    logic        OutValid;
    logic        OutReady;
    logic [4:0]  TotalCoeff;
    logic [1:0]  TrailingOnes;
    logic [4:0]  CodeLen;
    logic        Error;

    modport slave (
        input  Flush, InValid, InBits, NcClass,
        input  LutTotalCoeff, LutTrailingOnes, LutLen, LutHit,
        input  OutReady,
        output InReady, LutClass, LutPrefix, LutBits, LutReq,
        output OutValid, TotalCoeff, TrailingOnes, CodeLen, Error
    );

    modport master (
        output Flush, InValid, InBits, NcClass,
        output LutTotalCoeff, LutTrailingOnes, LutLen, LutHit,
        output OutReady,
        input  InReady, LutClass, LutPrefix, LutBits, LutReq,
        input  OutValid, TotalCoeff, TrailingOnes, CodeLen, Error
    );
endinterface

// File: rtl/coeff_token_ctrl.sv
// coeff_token decoder control: counts the leading-zero prefix of a 16-bit window,
// hands prefix/suffix to an external LUT bank and returns the decoded result.
module coeff_token_ctrl #(
    parameter int MAX_LZ = 15
) (
    input logic               Clk,
    input logic               nReset,
    coeff_token_ctrl_if.slave bus
);

    typedef enum logic [1:0] {IDLE, COUNT, LOOKUP, OUT} state_t;

    localparam logic [3:0] LZ_LIMIT = 4'(MAX_LZ);

    state_t      state_reg, state_next;
    logic [15:0] shift_reg, shift_next;
    logic [1:0]  cls_reg, cls_next;
    logic [3:0]  lz_reg, lz_next;
    logic        inv_reg, inv_next;
    logic        run_reg;
    logic [1:0]  lut_cls_reg, lut_cls_next;
    logic [3:0]  lut_pre_reg, lut_pre_next;
    logic [3:0]  lut_bits_reg, lut_bits_next;
    logic [4:0]  tc_reg, tc_next;
    logic [1:0]  t1_reg, t1_next;
    logic [4:0]  len_reg, len_next;
    logic        err_reg, err_next;
    logic        in_ready;
    logic [5:0]  fl_code;

    // run_reg keeps InReady low while in reset and raises it on the first edge after.
    assign in_ready = run_reg && (state_reg == IDLE);
    assign fl_code  = bus.InBits[15:10];

    always_comb begin
        state_next    = state_reg;
        shift_next    = shift_reg;
        cls_next      = cls_reg;
        lz_next       = lz_reg;
        inv_next      = inv_reg;
        lut_cls_next  = lut_cls_reg;
        lut_pre_next  = lut_pre_reg;
        lut_bits_next = lut_bits_reg;
        tc_next       = tc_reg;
        t1_next       = t1_reg;
        len_next      = len_reg;
        err_next      = err_reg;

        if (bus.Flush) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (bus.InValid && in_ready) begin
                        shift_next = bus.InBits;
                        cls_next   = bus.NcClass;
                        lz_next    = 4'd0;
                        inv_next   = 1'b0;
                        if (bus.NcClass == 2'd3) begin
                            // Fixed-length 6-bit code: decoded without the LUT bank.
                            len_next = 5'd6;
                            err_next = 1'b0;
                            if (fl_code == 6'b000011) begin
                                tc_next = 5'd0;
                                t1_next = 2'd0;
                            end else begin
                                tc_next = {1'b0, fl_code[5:2]} + 5'd1;
                                t1_next = fl_code[1:0];
                            end
                            state_next = OUT;
                        end else begin
                            state_next = COUNT;
                        end
                    end
                end
                COUNT: begin
                    if (shift_reg[15]) begin
                        lut_pre_next  = lz_reg;
                        lut_bits_next = shift_reg[14:11];
                        lut_cls_next  = cls_reg;
                        state_next    = LOOKUP;
                    end else if (lz_reg == LZ_LIMIT) begin
                        // Invalid prefix still passes through LOOKUP (without a LUT
                        // request) so its latency equals the longest valid prefix.
                        inv_next   = 1'b1;
                        state_next = LOOKUP;
                    end else begin
                        lz_next    = lz_reg + 4'd1;
                        shift_next = {shift_reg[14:0], 1'b0};
                    end
                end
                LOOKUP: begin
                    if (!inv_reg && bus.LutHit) begin
                        tc_next  = bus.LutTotalCoeff;
                        t1_next  = bus.LutTrailingOnes;
                        len_next = bus.LutLen;
                        err_next = 1'b0;
                    end else begin
                        tc_next  = 5'd0;
                        t1_next  = 2'd0;
                        len_next = 5'd0;
                        err_next = 1'b1;
                    end
                    state_next = OUT;
                end
                OUT: begin
                    if (bus.OutReady) begin
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state_reg    <= IDLE;
            shift_reg    <= 16'd0;
            cls_reg      <= 2'd0;
            lz_reg       <= 4'd0;
            inv_reg      <= 1'b0;
            run_reg      <= 1'b0;
            lut_cls_reg  <= 2'd0;
            lut_pre_reg  <= 4'd0;
            lut_bits_reg <= 4'd0;
            tc_reg       <= 5'd0;
            t1_reg       <= 2'd0;
            len_reg      <= 5'd0;
            err_reg      <= 1'b0;
        end else begin
            state_reg    <= state_next;
            shift_reg    <= shift_next;
            cls_reg      <= cls_next;
            lz_reg       <= lz_next;
            inv_reg      <= inv_next;
            run_reg      <= 1'b1;
            lut_cls_reg  <= lut_cls_next;
            lut_pre_reg  <= lut_pre_next;
            lut_bits_reg <= lut_bits_next;
            tc_reg       <= tc_next;
            t1_reg       <= t1_next;
            len_reg      <= len_next;
            err_reg      <= err_next;
        end
    end

    assign bus.InReady      = in_ready;
    assign bus.LutReq       = (state_reg == LOOKUP) && !inv_reg;
    assign bus.LutClass     = lut_cls_reg;
    assign bus.LutPrefix    = lut_pre_reg;
    assign bus.LutBits      = lut_bits_reg;
    assign bus.OutValid     = (state_reg == OUT);
    assign bus.TotalCoeff   = tc_reg;
    assign bus.TrailingOnes = t1_reg;
    assign bus.CodeLen      = len_reg;
    assign bus.Error        = err_reg;

endmodule

// File: tb/tb_coeff_token_ctrl.sv
// Self-checking bench for coeff_token_ctrl: directed corner cases plus random windows
// compared against a leading-zero/LUT reference model.
module tb_coeff_token_ctrl;

    localparam int MAX_LZ = 15;

    typedef struct packed {
        logic       hit;
        logic [4:0] tc;
        logic [1:0] t1;
        logic [4:0] len;
    } lut_t;

    logic Clk;
    logic nReset;
    int   n_checks;
    int   n_fail;
    lut_t lut_r;

    coeff_token_ctrl_if bus ();

    coeff_token_ctrl #(.MAX_LZ(MAX_LZ)) dut (
        .Clk    (Clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Environment LUT bank: one fixed entry plus an arbitrary but deterministic table.
    function automatic lut_t lut_model(input logic [1:0] c, input logic [3:0] p, input logic [3:0] b);
        lut_t r;
        if (c == 2'd1 && p == 4'd7 && b == 4'hF) begin
            r = '{hit: 1'b1, tc: 5'd9, t1: 2'd0, len: 5'd12};
        end else begin
            r.hit = ((int'(p) + int'(b) + int'(c)) % 5) != 0;
            r.tc  = 5'((int'(p) * 3 + int'(b)) % 17);
            r.t1  = b[1:0];
            r.len = 5'(int'(p) + 5);
        end
        return r;
    endfunction

    assign lut_r                = lut_model(bus.LutClass, bus.LutPrefix, bus.LutBits);
    assign bus.LutHit           = lut_r.hit;
    assign bus.LutTotalCoeff    = lut_r.tc;
    assign bus.LutTrailingOnes  = lut_r.t1;
    assign bus.LutLen           = lut_r.len;

    function automatic int lead_zeros(input logic [15:0] b);
        int n = 0;
        for (int i = 15; i >= 0; i--) begin
            if (b[i]) break;
            n++;
        end
        return n;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic accept_window(input logic [1:0] cls, input logic [15:0] bits);
        @(negedge Clk);
        check("accept_inready", 32'(bus.InReady), 32'd1);
        bus.InValid  = 1'b1;
        bus.InBits   = bits;
        bus.NcClass  = cls;
        bus.OutReady = 1'b0;
        @(posedge Clk);
        #1;
        bus.InValid = 1'b0;
    endtask

    task automatic run_window(input logic [1:0] cls, input logic [15:0] bits, input int hold);
        int         lz, lat, edges, req_cnt;
        logic       exp_req;
        logic [4:0] e_tc, e_len;
        logic [1:0] e_t1;
        logic       e_err;
        logic [15:0] tail;
        logic [3:0] nb, cap_pre, cap_bits;
        logic [1:0] cap_cls;
        lut_t       m;

        lz      = lead_zeros(bits);
        exp_req = 1'b0;
        nb      = 4'd0;
        if (cls == 2'd3) begin
            lat   = 0;
            e_len = 5'd6;
            e_err = 1'b0;
            if (bits[15:10] == 6'b000011) begin
                e_tc = 5'd0;
                e_t1 = 2'd0;
            end else begin
                e_tc = 5'(int'(bits[15:12]) + 1);
                e_t1 = bits[11:10];
            end
        end else if (lz > MAX_LZ) begin
            lat   = MAX_LZ + 2;
            e_tc  = 5'd0;
            e_t1  = 2'd0;
            e_len = 5'd0;
            e_err = 1'b1;
        end else begin
            lat     = lz + 2;
            exp_req = 1'b1;
            tail    = bits << (lz + 1);
            nb      = tail[15:12];
            m       = lut_model(cls, 4'(lz), nb);
            e_tc    = m.hit ? m.tc : 5'd0;
            e_t1    = m.hit ? m.t1 : 2'd0;
            e_len   = m.hit ? m.len : 5'd0;
            e_err   = !m.hit;
        end

        accept_window(cls, bits);
        edges    = 0;
        req_cnt  = 0;
        cap_pre  = 4'd0;
        cap_bits = 4'd0;
        cap_cls  = 2'd0;
        while (1) begin
            if (bus.LutReq) begin
                req_cnt++;
                cap_pre  = bus.LutPrefix;
                cap_bits = bus.LutBits;
                cap_cls  = bus.LutClass;
            end
            if (bus.OutValid || edges >= 40) break;
            @(posedge Clk);
            #1;
            edges++;
        end

        check("out_valid", 32'(bus.OutValid), 32'd1);
        check("latency", 32'(edges), 32'(lat));
        check("total_coeff", 32'(bus.TotalCoeff), 32'(e_tc));
        check("trailing_ones", 32'(bus.TrailingOnes), 32'(e_t1));
        check("code_len", 32'(bus.CodeLen), 32'(e_len));
        check("error", 32'(bus.Error), 32'(e_err));
        check("lutreq_count", 32'(req_cnt), exp_req ? 32'd1 : 32'd0);
        if (exp_req) begin
            check("lut_prefix", 32'(cap_pre), 32'(lz));
            check("lut_bits", 32'(cap_bits), 32'(nb));
            check("lut_class", 32'(cap_cls), 32'(cls));
        end
        $display("txn cls=%0d bits=%04h lz=%0d edges=%0d tc=%0d t1=%0d len=%0d err=%0d",
                 cls, bits, lz, edges, bus.TotalCoeff, bus.TrailingOnes, bus.CodeLen, bus.Error);

        for (int i = 0; i < hold; i++) begin
            @(posedge Clk);
            #1;
            check("hold_valid", 32'(bus.OutValid), 32'd1);
            check("hold_result", 32'({bus.TotalCoeff, bus.TrailingOnes, bus.CodeLen, bus.Error}),
                  32'({e_tc, e_t1, e_len, e_err}));
            check("hold_inready", 32'(bus.InReady), 32'd0);
        end

        @(negedge Clk);
        bus.OutReady = 1'b1;
        @(posedge Clk);
        #1;
        bus.OutReady = 1'b0;
        check("release_valid", 32'(bus.OutValid), 32'd0);
        check("release_inready", 32'(bus.InReady), 32'd1);
    endtask

    initial begin
        logic [1:0]  rc;
        logic [15:0] rb;
        int          sh;

        n_checks     = 0;
        n_fail       = 0;
        nReset       = 1'b1;
        bus.Flush    = 1'b0;
        bus.InValid  = 1'b0;
        bus.InBits   = 16'd0;
        bus.NcClass  = 2'd0;
        bus.OutReady = 1'b0;

        // Reset values while nReset is low
        #2 nReset = 1'b0;
        #1;
        check("rst_inready", 32'(bus.InReady), 32'd0);
        check("rst_outvalid", 32'(bus.OutValid), 32'd0);
        check("rst_lutreq", 32'(bus.LutReq), 32'd0);
        check("rst_result", 32'({bus.TotalCoeff, bus.TrailingOnes, bus.CodeLen, bus.Error}), 32'd0);
        check("rst_lut_inputs", 32'({bus.LutClass, bus.LutPrefix, bus.LutBits}), 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        @(posedge Clk);
        #1;
        check("post_rst_inready", 32'(bus.InReady), 32'd1);

        // Fixed-length class, both decode branches
        run_window(2'd3, 16'h0C00, 0);
        run_window(2'd3, 16'h1400, 0);
        // All-zero window: invalid, longest latency, no LUT request
        run_window(2'd0, 16'h0000, 0);
        // Longest valid prefix
        run_window(2'd0, 16'h0001, 0);
        // Consumer stall of 5 cycles
        run_window(2'd2, 16'h3000, 5);

        // Flush mid-count
        accept_window(2'd0, 16'h0010);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        bus.Flush = 1'b1;
        @(posedge Clk);
        #1;
        check("flush_outvalid", 32'(bus.OutValid), 32'd0);
        check("flush_inready", 32'(bus.InReady), 32'd1);
        check("flush_lutreq", 32'(bus.LutReq), 32'd0);
        @(negedge Clk);
        bus.Flush = 1'b0;
        repeat (3) begin
            @(posedge Clk);
            #1;
            check("flush_quiet", 32'(bus.OutValid), 32'd0);
        end
        run_window(2'd2, 16'h2A00, 0);

        // Flush in IDLE blocks an offered window
        @(negedge Clk);
        bus.Flush   = 1'b1;
        bus.InValid = 1'b1;
        bus.InBits  = 16'h0C00;
        bus.NcClass = 2'd3;
        @(posedge Clk);
        #1;
        bus.Flush   = 1'b0;
        bus.InValid = 1'b0;
        check("flush_idle_noaccept", 32'(bus.OutValid), 32'd0);
        check("flush_idle_inready", 32'(bus.InReady), 32'd1);

        // Reset mid-decode
        accept_window(2'd1, 16'h0100);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        nReset = 1'b0;
        #1;
        check("midrst_inready", 32'(bus.InReady), 32'd0);
        check("midrst_outvalid", 32'(bus.OutValid), 32'd0);
        check("midrst_result", 32'({bus.TotalCoeff, bus.TrailingOnes, bus.CodeLen, bus.Error}), 32'd0);
        @(negedge Clk);
        nReset = 1'b1;
        @(posedge Clk);
        #1;
        check("midrst_post_inready", 32'(bus.InReady), 32'd1);
        check("midrst_post_outvalid", 32'(bus.OutValid), 32'd0);
        // LUT hit with prefix 7 and suffix 1111
        run_window(2'd1, 16'h01F0, 1);

        // Random windows with a spread of prefix lengths
        for (int k = 0; k < 40; k++) begin
            rc = 2'($urandom_range(0, 3));
            sh = $urandom_range(0, 17);
            rb = 16'($urandom);
            rb = (sh >= 16) ? 16'd0 : (rb >> sh);
            run_window(rc, rb, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
